// File: rtl/regsel_encoder_5bits.sv
// Serialises a 32-bit register-select bitmap into 5-bit indices, lowest first,
// one per valid/ready handshake. Every output comes straight from a register.
module regsel_encoder_5bits #(
  parameter int N_SEL = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_SEL-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   pending_cnt,
  input  logic             abort,
  output logic             zero_drop
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [N_SEL-1:0]   pend_q, pend_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic               in_ready_q, out_valid_q, out_last_q, zero_drop_q, zero_drop_d;
  logic [IDX_W-1:0]   out_idx_q;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SEL-1:0] v);
    lowest_idx = '0;
    for (int i = N_SEL-1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W:0] popcnt(input logic [N_SEL-1:0] v);
    popcnt = '0;
    for (int i = 0; i < N_SEL; i++)
      popcnt = popcnt + {{IDX_W{1'b0}}, v[i]};
  endfunction

  // abort outranks both handshakes; a coincident out_ready is discarded.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    zero_drop_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            if (in_bits != '0) begin
              pend_d  = in_bits;
              cnt_d   = popcnt(in_bits);
              state_d = S_EMIT;
            end else begin
              zero_drop_d = 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            // clearing the lowest set bit == clearing bit out_idx_q
            pend_d = pend_q & (pend_q - N_SEL'(1));
            cnt_d  = cnt_q - (IDX_W+1)'(1);
            if (out_last_q) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_EMIT);
      out_idx_q   <= lowest_idx(pend_d);
      out_last_q  <= (state_d == S_EMIT) && (cnt_d == (IDX_W+1)'(1));
      zero_drop_q <= zero_drop_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_last_q;
  assign pending_cnt = cnt_q;
  assign zero_drop   = zero_drop_q;

endmodule

// File: tb/tb_regsel_encoder_5bits.sv
// Bench for regsel_encoder_5bits: vector table of bitmaps drained through a
// scoreboard, plus hand sequences for abort and asynchronous reset mid-emit.
module tb_regsel_encoder_5bits;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_bits;
  logic        out_valid, out_ready, out_last, abort, zero_drop;
  logic [4:0]  out_idx;
  logic [5:0]  pending_cnt;

  regsel_encoder_5bits dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .pending_cnt(pending_cnt),
    .abort(abort), .zero_drop(zero_drop)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] idx; logic last; logic [5:0] cnt; } exp_t;
  typedef struct { logic [31:0] bits; int mode; int exp_n; } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0, n_bad = 0, nhs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: set bits listed low to high with remaining count before each.
  task automatic push_exp(input logic [31:0] b);
    int   rem;
    exp_t e;
    rem = 0;
    for (int i = 0; i < 32; i++) if (b[i]) rem++;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        e.idx = 5'(i); e.last = (rem == 1); e.cnt = 6'(rem);
        sb.push_back(e);
        rem--;
      end
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clock); #1; k++;
    end
    if (!in_ready) chk("wait_in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [31:0] b);
    wait_ready();
    in_valid = 1'b1; in_bits = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    push_exp(b);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
  task automatic drain(input int mode);
    int k;
    exp_t e;
    k = 0; nhs = 0;
    while (sb.size() > 0 && k < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (k % 2 == 0);
      @(negedge clock);
      chk("out_valid_emit", 32'(out_valid), 32'd1);
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      if (out_valid) begin
        e = sb[0];
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
        chk("pending_cnt", 32'(pending_cnt), 32'(e.cnt));
        if (out_ready) begin
          void'(sb.pop_front());
          nhs++;
        end
      end
      @(posedge clock); #1; k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    out_ready = 1'b0;
    @(negedge clock);
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd1);
    chk("pending_cnt_done", 32'(pending_cnt), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.bits == 32'h0) begin
      wait_ready();
      in_valid = 1'b1; in_bits = 32'h0;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("zero_drop_pulse", 32'(zero_drop), 32'd1);
      chk("zero_out_valid", 32'(out_valid), 32'd0);
      chk("zero_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      chk("zero_drop_clear", 32'(zero_drop), 32'd0);
      chk("zero_out_valid2", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
    end else begin
      accept(v.bits);
      drain(v.mode);
      chk("handshakes", 32'(nhs), 32'(v.exp_n));
    end
  endtask

  initial begin
    vec_t r2;
    vecs[0] = '{32'h0000_0001, 0, 1};
    vecs[1] = '{32'h8000_0014, 0, 3};
    vecs[2] = '{32'hFFFF_FFFF, 1, 32};
    vecs[3] = '{32'h0000_0000, 0, 0};
    vecs[4] = '{32'hA5A5_0000, 1, 8};
    vecs[5] = '{32'h8000_0000, 0, 1};

    ctrl_reset_n = 1'b0; in_valid = 1'b0; in_bits = '0;
    out_ready = 1'b0; abort = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_pending_cnt", 32'(pending_cnt), 32'd0);
    chk("rst_zero_drop", 32'(zero_drop), 32'd0);
    ctrl_reset_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // abort with out_ready on second index: only index 8 consumed
    accept(32'h0000_0F00);
    nhs = 0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("abort_first_idx", 32'(out_idx), 32'(sb[0].idx));
    void'(sb.pop_front()); nhs++;
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    chk("abort_second_idx", 32'(out_idx), 32'(sb[0].idx));
    @(posedge clock); #1;
    abort = 1'b0; out_ready = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_pending_cnt", 32'(pending_cnt), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_handshakes", 32'(nhs), 32'd1);
    @(posedge clock); #1;

    // abort in IDLE blocks a simultaneous in_valid
    abort = 1'b1; in_valid = 1'b1; in_bits = 32'h5;
    @(posedge clock); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("abort_idle_out_valid", 32'(out_valid), 32'd0);
    chk("abort_idle_cnt", 32'(pending_cnt), 32'd0);
    @(posedge clock); #1;

    // asynchronous reset after index 8 of 0x0F00
    accept(32'h0000_0F00);
    out_ready = 1'b1;
    @(negedge clock);
    chk("rst_mid_first_idx", 32'(out_idx), 32'(sb[0].idx));
    @(posedge clock); #1;
    out_ready = 1'b0;
    ctrl_reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_cnt", 32'(pending_cnt), 32'd0);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    #1 ctrl_reset_n = 1'b1;
    r2 = '{32'h0000_0002, 0, 1};
    run_vec(r2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
